aes_key_expand_gen: RTL

Parametrised AES key-expansion engine for AES-128/192/256, selected by KEY_BITS. It generates one expanded 32-bit word per cycle and packs every four words into a 128-bit round key. Round keys are emitted in order on a valid/ready stream, rk0 first and rk(Nr) last. It feeds the round datapath in place of the fixed AES-128 key-generation process.

---
 rtl/aes_key_expand_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand_gen.sv
// AES-128/192/256 key expansion: one expanded word per cycle, packed four at a time into round keys on a valid/ready stream.
// Define AES_KEYEXP_RKSTORE_EN to keep every round key in a readable store (rd_idx -> rd_key, one cycle latency).
module aes_key_expand_gen #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    localparam int NK     = KEY_BITS / 32;
    localparam int NR     = NK + 6;
    localparam int NWORDS = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand_gen: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, FLUSH} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = multiplicative inverse (a^254, 0 maps to 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t       state_q;
    logic [31:0]  win_q [NK];
    logic [5:0]   i_q;
    logic [2:0]   j_q;
    logic [7:0]   rcon_q;
    logic [95:0]  pack_q;
    logic         busy_q, rk_valid_q, rk_last_q, done_q;
    logic [127:0] rk_data_q;
    logic [3:0]   rk_idx_q;

    logic         stall, accept, pack_full;
    logic [31:0]  t_word, w_d;
    logic [2:0]   j_d;
    logic [7:0]   rcon_d;
    logic         key_lsb_unused;

    assign key_lsb_unused = ^key_in[127:0];

    // Window holds w[i-Nk..i-1] oldest first; while i < Nk it just rotates the key words.
    always_comb begin
        t_word = win_q[NK-1];
        if (j_q == 3'd0)
            t_word = sub_word({win_q[NK-1][23:0], win_q[NK-1][31:24]}) ^ {rcon_q, 24'h0};
        else if (NK == 8 && j_q == 3'd4)
            t_word = sub_word(win_q[NK-1]);
        w_d    = (i_q < 6'(NK)) ? win_q[0] : (win_q[0] ^ t_word);
        j_d    = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
        rcon_d = rcon_q;
        if (i_q >= 6'(NK) && j_q == 3'd0)
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    assign stall     = rk_valid_q && !rk_ready;
    assign accept    = rk_valid_q && rk_ready;
    assign pack_full = (state_q == EXPAND) && !stall && (i_q[1:0] == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            done_q     <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            rcon_q     <= 8'h01;
            pack_q     <= '0;
            for (int k = 0; k < NK; k++) win_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            if (kld) begin
                for (int k = 0; k < NK; k++) win_q[k] <= key_in[255-32*k -: 32];
                i_q        <= '0;
                j_q        <= '0;
                rcon_q     <= 8'h01;
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
                rk_idx_q   <= '0;
                busy_q     <= 1'b1;
                state_q    <= EXPAND;
            end else begin
                case (state_q)
                    IDLE: ;
                    EXPAND: begin
                        if (!stall) begin
                            for (int k = 0; k < NK - 1; k++) win_q[k] <= win_q[k+1];
                            win_q[NK-1] <= w_d;
                            pack_q      <= {pack_q[63:0], w_d};
                            i_q         <= i_q + 6'd1;
                            j_q         <= j_d;
                            rcon_q      <= rcon_d;
                            if (pack_full) begin
                                rk_valid_q <= 1'b1;
                                rk_data_q  <= {pack_q, w_d};
                                rk_idx_q   <= i_q[5:2];
                                rk_last_q  <= (i_q[5:2] == 4'(NR));
                            end else if (accept) begin
                                rk_valid_q <= 1'b0;
                                rk_last_q  <= 1'b0;
                            end
                            if (i_q == 6'(NWORDS - 1)) state_q <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (accept) begin
                            rk_valid_q <= 1'b0;
                            rk_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign rk_last  = rk_last_q;
    assign done     = done_q;

`ifdef AES_KEYEXP_RKSTORE_EN
    logic [127:0] store_q [15];
    logic [127:0] rd_key_q;

    // Store survives kld so a previous schedule stays readable until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 15; k++) store_q[k] <= '0;
            rd_key_q <= '0;
        end else begin
            if (pack_full && !kld) store_q[i_q[5:2]] <= {pack_q, w_d};
            rd_key_q <= (rd_idx <= 4'(NR)) ? store_q[rd_idx] : '0;
        end
    end

    assign rd_key = rd_key_q;
`else
    logic rd_idx_unused;
    assign rd_idx_unused = ^rd_idx;
    assign rd_key        = '0;
`endif

endmodule
